link_token_sink: RTL and testbench

Downstream consumer of a link stage's output bundle (wen/token/clk_cnt/id). It terminates the last link in the chain and checks each delivered token:
- token sequence is contiguous;
- id matches the expected link;
- transit latency, from the carried clk_cnt to the local cycle count, stays within a bound.

It raises a one-cycle benchmark event when the programmed number of tokens has arrived and exposes sticky status and statistics to the testbench and shunt fringe.

---
 rtl/link_token_sink.sv | 112 +++++++++++
 tb/tb_link_token_sink.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/link_token_sink.sv
// Terminating sink for the last link in a token chain: checks sequence, id and
// transit latency of each token, collects statistics and flags completion.
module link_token_sink #(
    parameter logic [31:0] EXP_ID      = 32'd0,
    parameter logic [31:0] N_TOKENS    = 32'd1000,
    parameter logic [31:0] LAT_MAX     = 32'd64,
    parameter logic [31:0] FIRST_TOKEN = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_wen,
    input  logic [31:0] i_token,
    input  logic [31:0] i_clk_cnt,
    input  logic [31:0] i_id,
    output logic [1:0]  o_state,
    output logic [31:0] o_tok_cnt,
    output logic [31:0] o_lat_min,
    output logic [31:0] o_lat_max,
    output logic        o_benchmark_event,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [31:0] o_err_token,
    output logic        o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cyc;
    logic [31:0] exp_tok;
    logic [31:0] latency;
    logic [1:0]  code_nxt;
    logic        checking;
    logic        good;
    logic        bad;
    logic        last;

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        latency  = cyc - i_clk_cnt;
        checking = i_wen && ((state == S_IDLE) || (state == S_RUN));
        code_nxt = 2'd0;
        if (i_token != exp_tok)
            code_nxt = 2'd1;
        else if (i_id != EXP_ID)
            code_nxt = 2'd2;
        else if (latency > LAT_MAX)
            code_nxt = 2'd3;
        good      = checking && (code_nxt == 2'd0);
        bad       = checking && (code_nxt != 2'd0);
        last      = (o_tok_cnt + 32'd1) == N_TOKENS;
        state_nxt = state;
        if (bad)
            state_nxt = S_ERR;
        else if (good)
            state_nxt = last ? S_DONE : S_RUN;
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cyc               <= 32'd0;
            exp_tok           <= FIRST_TOKEN;
            o_tok_cnt         <= 32'd0;
            o_lat_min         <= 32'hFFFF_FFFF;
            o_lat_max         <= 32'd0;
            o_benchmark_event <= 1'b0;
            o_err_code        <= 2'd0;
            o_err_token       <= 32'd0;
            o_overrun         <= 1'b0;
        end else begin
            cyc               <= cyc + 32'd1;
            o_benchmark_event <= (state_nxt == S_DONE) && (state != S_DONE);
            if (good) begin
                o_tok_cnt <= o_tok_cnt + 32'd1;
                exp_tok   <= exp_tok + 32'd1;
                if (o_tok_cnt == 32'd0) begin
                    o_lat_min <= latency;
                    o_lat_max <= latency;
                end else begin
                    if (latency < o_lat_min) o_lat_min <= latency;
                    if (latency > o_lat_max) o_lat_max <= latency;
                end
            end
            if (bad) begin
                o_err_code  <= code_nxt;
                o_err_token <= i_token;
            end
            if ((state == S_DONE) && i_wen)
                o_overrun <= 1'b1;
        end
    end

    assign o_state = state;
    assign o_done  = (state == S_DONE);
    assign o_err   = (state == S_ERR);

endmodule

// File: tb/tb_link_token_sink.sv
// Bench for link_token_sink: table of token vectors with expected outputs fed
// through a scoreboard queue, plus a hand-written overrun sequence.
module tb_link_token_sink;

    typedef struct {
        logic        rst;
        int          dut;
        logic        wen;
        logic [31:0] tok;
        logic [31:0] id;
        logic [31:0] lat;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic [31:0] lmin;
        logic [31:0] lmax;
        logic        ev;
        logic [1:0]  code;
        logic [31:0] etok;
        logic        ovr;
    } vec_t;

    localparam logic [31:0] F = 32'hFFFF_FFFF;

    logic        clk;
    logic        rstn [3];
    logic        wen;
    logic [31:0] token, clk_cnt, id;
    logic [1:0]  st   [3];
    logic [31:0] cnt  [3];
    logic [31:0] lmin [3];
    logic [31:0] lmax [3];
    logic        ev   [3];
    logic        done [3];
    logic        err  [3];
    logic [1:0]  code [3];
    logic [31:0] etok [3];
    logic        ovr  [3];

    logic [31:0] tb_cyc;
    int          n_checks;
    int          n_fail;
    vec_t        sb  [$];
    vec_t        tbl [$];

    link_token_sink #(.EXP_ID(32'd3), .N_TOKENS(32'd4), .LAT_MAX(32'd64), .FIRST_TOKEN(32'd0)) dut_a (
        .i_clk(clk), .i_rstn(rstn[0]), .i_wen(wen), .i_token(token), .i_clk_cnt(clk_cnt), .i_id(id),
        .o_state(st[0]), .o_tok_cnt(cnt[0]), .o_lat_min(lmin[0]), .o_lat_max(lmax[0]),
        .o_benchmark_event(ev[0]), .o_done(done[0]), .o_err(err[0]), .o_err_code(code[0]),
        .o_err_token(etok[0]), .o_overrun(ovr[0]));

    link_token_sink #(.EXP_ID(32'd3), .N_TOKENS(32'd4), .LAT_MAX(32'd64), .FIRST_TOKEN(32'hFFFF_FFFE)) dut_b (
        .i_clk(clk), .i_rstn(rstn[1]), .i_wen(wen), .i_token(token), .i_clk_cnt(clk_cnt), .i_id(id),
        .o_state(st[1]), .o_tok_cnt(cnt[1]), .o_lat_min(lmin[1]), .o_lat_max(lmax[1]),
        .o_benchmark_event(ev[1]), .o_done(done[1]), .o_err(err[1]), .o_err_code(code[1]),
        .o_err_token(etok[1]), .o_overrun(ovr[1]));

    link_token_sink #(.EXP_ID(32'd3), .N_TOKENS(32'd1), .LAT_MAX(32'd64), .FIRST_TOKEN(32'd0)) dut_c (
        .i_clk(clk), .i_rstn(rstn[2]), .i_wen(wen), .i_token(token), .i_clk_cnt(clk_cnt), .i_id(id),
        .o_state(st[2]), .o_tok_cnt(cnt[2]), .o_lat_min(lmin[2]), .o_lat_max(lmax[2]),
        .o_benchmark_event(ev[2]), .o_done(done[2]), .o_err(err[2]), .o_err_code(code[2]),
        .o_err_token(etok[2]), .o_overrun(ovr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input int d, input logic w, input logic [31:0] tk,
                                input logic [31:0] i, input logic [31:0] l, input logic [1:0] s,
                                input logic [31:0] c, input logic [31:0] mn, input logic [31:0] mx,
                                input logic e, input logic [1:0] cd, input logic [31:0] et,
                                input logic ov);
        vec_t v;
        v.rst = r; v.dut = d; v.wen = w; v.tok = tk; v.id = i; v.lat = l;
        v.st = s; v.cnt = c; v.lmin = mn; v.lmax = mx; v.ev = e; v.code = cd;
        v.etok = et; v.ovr = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic compare_out(input vec_t e, input string tag);
        int d = e.dut;
        check({tag, " state"},     {30'd0, st[d]},   {30'd0, e.st});
        check({tag, " tok_cnt"},   cnt[d],           e.cnt);
        check({tag, " lat_min"},   lmin[d],          e.lmin);
        check({tag, " lat_max"},   lmax[d],          e.lmax);
        check({tag, " event"},     {31'd0, ev[d]},   {31'd0, e.ev});
        check({tag, " done"},      {31'd0, done[d]}, {31'd0, e.st == 2'd2});
        check({tag, " err"},       {31'd0, err[d]},  {31'd0, e.st == 2'd3});
        check({tag, " err_code"},  {30'd0, code[d]}, {30'd0, e.code});
        check({tag, " err_token"}, etok[d],          e.etok);
        check({tag, " overrun"},   {31'd0, ovr[d]},  {31'd0, e.ovr});
    endtask

    task automatic pop_compare(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            compare_out(e, tag);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, compare after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        wen     = v.wen;
        token   = v.tok;
        id      = v.id;
        clk_cnt = tb_cyc - v.lat;
        sb.push_back(v);
        @(posedge clk);
        tb_cyc = tb_cyc + 32'd1;
        @(negedge clk);
        pop_compare(tag);
        wen = 1'b0;
    endtask

    // One reset cycle with a valid token on the bus that must be dropped.
    task automatic do_reset(input int d, input string tag);
        for (int k = 0; k < 3; k++) rstn[k] = 1'b0;
        wen     = 1'b1;
        token   = 32'd2;
        id      = 32'd3;
        clk_cnt = 32'd0;
        sb.push_back(mk(0, d, 0, 0, 0, 0, 2'd0, 0, F, 0, 0, 2'd0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        pop_compare({tag, " reset"});
        rstn[d] = 1'b1;
        wen     = 1'b0;
        tb_cyc  = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tb_cyc   = 32'd0;
        wen      = 1'b0;
        token    = 32'd0;
        clk_cnt  = 32'd0;
        id       = 32'd0;
        for (int k = 0; k < 3; k++) rstn[k] = 1'b0;

        // Sequence error after two good tokens; ERR then ignores a correct token.
        tbl.push_back(mk(1, 0, 1, 0, 3,  5, 2'd1, 1,  5,  5, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3,  5, 2'd1, 2,  5,  5, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3, 3,  5, 2'd3, 2,  5,  5, 0, 2'd1, 3, 0));
        tbl.push_back(mk(0, 0, 1, 2, 3,  5, 2'd3, 2,  5,  5, 0, 2'd1, 3, 0));
        // Id error, latency error, and both sequence and id wrong.
        tbl.push_back(mk(1, 0, 1, 0, 5,  5, 2'd3, 0,  F,  0, 0, 2'd2, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 3, 65, 2'd3, 0,  F,  0, 0, 2'd3, 0, 0));
        tbl.push_back(mk(1, 0, 1, 7, 9,  5, 2'd3, 0,  F,  0, 0, 2'd1, 7, 0));
        // Latency exactly at the bound is legal, one above is not.
        tbl.push_back(mk(1, 0, 1, 0, 3, 64, 2'd1, 1, 64, 64, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 65, 2'd3, 1, 64, 64, 0, 2'd3, 1, 0));
        // Final token fails a check: ERR, no completion pulse.
        tbl.push_back(mk(1, 0, 1, 0, 3, 10, 2'd1, 1, 10, 10, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 11, 2'd1, 2, 10, 11, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 3, 12, 2'd1, 3, 10, 12, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3, 4, 13, 2'd3, 3, 10, 12, 0, 2'd2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 2'd3, 3, 10, 12, 0, 2'd2, 3, 0));
        // Token wrap FFFFFFFE..1 with stamps from before the cycle counter wrap.
        tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFFE, 3, 7, 2'd1, 1, 7, 7, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFF, 3, 3, 2'd1, 2, 3, 7, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,             3, 9, 2'd1, 3, 3, 9, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1,             3, 2, 2'd2, 4, 2, 9, 1, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,             0, 0, 2'd2, 4, 2, 9, 0, 2'd0, 0, 0));
        // N_TOKENS=1: IDLE goes straight to DONE; a later token is an overrun.
        tbl.push_back(mk(1, 2, 1, 0, 3, 1, 2'd2, 1, 1, 1, 1, 2'd0, 0, 0));
        tbl.push_back(mk(0, 2, 1, 1, 3, 1, 2'd2, 1, 1, 1, 0, 2'd0, 0, 1));
        // Reset mid-run after two tokens, then a normal back-to-back run to completion.
        tbl.push_back(mk(1, 0, 1, 0, 3, 10, 2'd1, 1, 10, 10, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 12, 2'd1, 2, 10, 12, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 3, 10, 2'd1, 1, 10, 10, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 3, 12, 2'd1, 2, 10, 12, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 3,  8, 2'd1, 3,  8, 12, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3, 3, 20, 2'd2, 4,  8, 20, 1, 2'd0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset(tbl[i].dut, $sformatf("v%0d", i));
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // DUT A is now in DONE: three overrun tokens, then an idle cycle.
        for (int k = 0; k < 3; k++)
            apply(mk(0, 0, 1, 4 + k, 3, 0, 2'd2, 4, 8, 20, 0, 2'd0, 0, 1), $sformatf("overrun%0d", k));
        apply(mk(0, 0, 0, 0, 0, 0, 2'd2, 4, 8, 20, 0, 2'd0, 0, 1), "post_overrun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
